// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous data memory between the
// instruction-fetch port (read-only) and the load/store port (read/write).
// One access is in flight at a time; each completion is signalled with a
// one-cycle acknowledge on the owning port.
//
// Optional feature macro: ARB_STARVE_GUARD_EN
//   defined   : after STARVE_LIMIT consecutive data grants made while fetch
//               was waiting, the next grant goes to fetch.
//   undefined : strict data priority, fetch may wait indefinitely.
//
// Parameters: ADDR_W word-address width, DATA_W data width,
//             MEM_LAT memory read latency (1..4), STARVE_LIMIT (1..15).
// Ports:
//   clk, rst                      clock, async active-high reset
//   if_req/if_addr                fetch request and word address
//   if_rdata/if_ack               fetch read data (registered), done pulse
//   d_req/d_we/d_addr/d_wdata     load/store request, 1 = store
//   d_rdata/d_ack                 load data (registered), done pulse
//   mem_en/mem_we                 memory strobe / write enable (ISSUE only)
//   mem_addr/mem_wdata            latched address / write data
//   mem_rdata                     memory read data, MEM_LAT cycles after strobe
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; arbitration and latching happen here
// ISSUE | memory strobe asserted for the latched request
// WAIT  | counting down read latency, capture read data at zero
// RESP  | acknowledge pulse to the granted port

module mem_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
    $error("mem_arbiter: MEM_LAT must be 1..4");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("mem_arbiter: STARVE_LIMIT must be 1..15");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

  state_t     state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic       sel_d;     // 1 = current access belongs to the load/store port
  logic       lat_we;
  logic       take;
  logic       capture;
  logic       grant_d;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt;

  assign grant_d = d_req && !(if_req && starve_cnt == 4'(STARVE_LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (take) begin
      if (!grant_d) begin
        starve_cnt <= '0;
      end else if (if_req && starve_cnt != 4'hF) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end
`else
  assign grant_d = d_req;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    take      = 1'b0;
    capture   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    if_ack    = 1'b0;
    d_ack     = 1'b0;
    case (state)
      IDLE: begin
        if (if_req || d_req) begin
          take      = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        mem_en = 1'b1;
        mem_we = lat_we;
        if (lat_we) begin
          state_nxt = RESP;
        end else begin
          cnt_nxt   = CNT_INIT;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 2'd0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 2'd1;
        end
      end
      RESP: begin
        if_ack    = !sel_d;
        d_ack     = sel_d;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sel_d     <= 1'b0;
      lat_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (take) begin
        sel_d    <= grant_d;
        lat_we   <= grant_d && d_we;
        mem_addr <= grant_d ? d_addr : if_addr;
        // fetch carries no write data; keep the previous value on the bus
        if (grant_d) begin
          mem_wdata <= d_wdata;
        end
      end
      if (capture && sel_d) begin
        d_rdata <= mem_rdata;
      end
      if (capture && !sel_d) begin
        if_rdata <= mem_rdata;
      end
    end
  end

endmodule
